reg_addr_scoreboard: RTL and testbench
======================================

Name: reg_addr_scoreboard

Overview:
- Parametrised successor to the single-cycle register-address selector for the pipelined MIPS core.
- Decodes source and destination register addresses from instruction fields by instruction class.
- Tracks in-flight writes per register in a counting scoreboard and stalls issue on RAW hazards.
- Presents decoded addresses through a registered valid/ready stage to the register-file read stage.

Parameters:
ADDR_W, 5, register address width
NREG, 32, number of architectural registers (must equal 2**ADDR_W)
CNT_W, 2, per-register pending-write counter width; max in-flight writes per register = 2**CNT_W-1
LINK_REG, 31, destination used by J-class link instructions

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush
in_valid  in  1  decoded instruction fields valid
in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
rs  in  ADDR_W  instruction rs field
rt  in  ADDR_W  instruction rt field
rd  in  ADDR_W  instruction rd field
optype  in  2  0=R, 1=I, 2=J, 3=JR
rt_src  in  1  I-class only: 1 = rt is a source (store/branch); 0 = rt is the destination
link  in  1  J/JR-class: instruction writes a link register
out_valid  out  1  output stage holds an issued instruction
out_ready  in  1  downstream accepts output
raddr1, raddr2  out  ADDR_W each  source addresses
ruse1, ruse2  out  1 each  source address meaningful
waddr  out  ADDR_W  destination address
wuse  out  1  destination meaningful
wb_valid  in  1  writeback retires one write
wb_addr  in  ADDR_W  register being retired
sb_err  out  1  sticky: retire to a register with count 0
pend_any  out  1  any counter nonzero

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0; out_valid 0; raddr1/2, waddr 0; ruse1/2, wuse 0; sb_err 0.
- Decode (combinational, from inputs):
  - R: src rs, rt; dst rd.
  - I: src rs; if rt_src, src rt and no dst; else dst rt.
  - J: no src; dst LINK_REG if link, else none.
  - JR: src rs; dst rd if link, else none.
  - Unused address outputs are driven 0.
  - A dst of register 0 is treated as no dst: wuse=0, no counter change.
  - A source of register 0 never causes a hazard.
- Hazard evaluation:
  - Uses registered counters from before this cycle's retire. There is no same-cycle bypass.
  - RAW: any used source with count != 0.
  - Saturation: dst count == 2**CNT_W-1.
  - WAW with count below max is allowed.
- Handshake:
  - space = !out_valid || out_ready.
  - in_ready = space && !hazard && !flush.
  - in_ready does not depend on in_valid.
- Accept (in_valid && in_ready): next edge loads the output stage, sets out_valid, and increments the dst counter if wuse.
- Output stage: holds stable while out_valid && !out_ready. It clears when out_ready is high and nothing is accepted.
- Latency: accept to out_valid is 1 cycle. Back-to-back throughput is 1 per cycle when there are no hazards.
- Retire (wb_valid, wb_addr != 0):
  - Decrements that counter.
  - If the count is 0, no change and sb_err sets (sticky until reset).
  - wb_addr == 0 is ignored.
- Same register on one edge:
  - Increment and decrement together leave the count net unchanged.
  - A retire at count 0 with a simultaneous increment gives a net count of 1, and sb_err is not set.
- Flush: takes priority over accept and retire. On the next edge all counters are 0 and out_valid is 0; sb_err is unchanged.
- pend_any is the OR of all counter-nonzero flags, taken from registered state.
- Reset asserted mid-operation returns immediately to the reset values. No accept occurs while rst_n is low.

Test Plan:
- R-type after reset: rs=1, rt=2, rd=3, in_valid=1, out_ready=1 → next cycle out_valid=1, raddr1=1, raddr2=2, waddr=3, wuse=1, count[3]=1, pend_any=1.
- RAW stall: after the above, issue I-type rs=3, rt=4, rt_src=0 → in_ready=0. Then wb_valid=1, wb_addr=3 → in_ready=1 the following cycle; the instruction issues with waddr=4.
- Saturation with CNT_W=2: three writes to rd=5 without retire → count=3. A fourth write to rd=5 holds in_ready=0 until one wb to 5.
- Backpressure: out_ready=0 with out_valid=1 → outputs stable for 4 cycles and in_ready=0. Then out_ready=1 → the next instruction loads in the same cycle.
- Register 0 and link cases:
  - R-type rd=0 → wuse=0, pend_any unchanged.
  - J link=1 → waddr=31, count[31]=1.
  - wb_addr=7 with count 0 → sb_err=1 and stays 1.
- Flush and async reset:
  - flush=1 with counts nonzero and out_valid=1 → next cycle pend_any=0, out_valid=0.
  - rst_n low mid-cycle → outputs 0 immediately.

Source files
------------

// File: rtl/reg_addr_scoreboard_if.sv
// Issue, output-stage and writeback signals of the register-address scoreboard.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is computed without looking at in_valid; once out_valid rises,
// the output stage keeps its contents unchanged until out_ready is seen high.
interface reg_addr_scoreboard_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] rd;
  logic [1:0]        optype;
  logic              rt_src;
  logic              link;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [ADDR_W-1:0] waddr;
  logic              ruse1;
  logic              ruse2;
  logic              wuse;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;

  modport master (
    output in_valid, rs, rt, rd, optype, rt_src, link, out_ready, wb_valid, wb_addr,
    input  in_ready, out_valid, raddr1, raddr2, waddr, ruse1, ruse2, wuse
  );

  modport slave (
    input  in_valid, rs, rt, rd, optype, rt_src, link, out_ready, wb_valid, wb_addr,
    output in_ready, out_valid, raddr1, raddr2, waddr, ruse1, ruse2, wuse
  );
endinterface

// File: rtl/reg_addr_scoreboard.sv
// Register-address decode with a counting write scoreboard. Each architectural
// register has a pending-write counter; issue stalls on RAW hazards or when the
// destination counter is saturated. Decoded addresses leave through a single
// registered valid/ready stage. The interface ADDR_W must match this module's.
module reg_addr_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int CNT_W    = 2,
  parameter int LINK_REG = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  reg_addr_scoreboard_if.slave  bus,
  output logic                  sb_err,
  output logic                  pend_any
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt [NREG];
  logic [ADDR_W-1:0] src1, src2, dst;
  logic              use1, use2, dst_use;
  logic              hazard, space, accept;
  logic              retire_ok, err_hit;
  logic [NREG-1:0]   inc_vec, dec_vec;

  // Decode source/destination addresses by instruction class; register 0 is never a destination
  always_comb begin
    src1    = '0;
    src2    = '0;
    dst     = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    case (bus.optype)
      2'd0: begin
        src1 = bus.rs; use1 = 1'b1;
        src2 = bus.rt; use2 = 1'b1;
        dst  = bus.rd;
      end
      2'd1: begin
        src1 = bus.rs; use1 = 1'b1;
        if (bus.rt_src) begin
          src2 = bus.rt; use2 = 1'b1;
        end else begin
          dst = bus.rt;
        end
      end
      2'd2: begin
        if (bus.link) dst = ADDR_W'(LINK_REG);
      end
      default: begin
        src1 = bus.rs; use1 = 1'b1;
        if (bus.link) dst = bus.rd;
      end
    endcase
    dst_use = (dst != '0);
  end

  // Hazards use the counters as registered before this edge's retire (no bypass)
  always_comb begin
    hazard = (use1 && (src1 != '0) && (cnt[src1] != '0)) ||
             (use2 && (src2 != '0) && (cnt[src2] != '0)) ||
             (dst_use && (cnt[dst] == CNT_MAX));
    space        = !bus.out_valid || bus.out_ready;
    bus.in_ready = space && !hazard && !flush;
    accept       = bus.in_valid && bus.in_ready;
  end

  // Per-register increment/decrement requests; a retire at count 0 is an error unless an increment cancels it
  always_comb begin
    retire_ok = bus.wb_valid && (bus.wb_addr != '0) && (cnt[bus.wb_addr] != '0);
    err_hit   = bus.wb_valid && (bus.wb_addr != '0) && (cnt[bus.wb_addr] == '0) &&
                !(accept && dst_use && (dst == bus.wb_addr));
    for (int i = 0; i < NREG; i++) begin
      inc_vec[i] = accept && dst_use && (dst == ADDR_W'(i));
      dec_vec[i] = retire_ok && (bus.wb_addr == ADDR_W'(i));
    end
  end

  // Pending-write counters; flush clears them all and wins over accept/retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Sticky scoreboard error; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (!flush && err_hit) begin
      sb_err <= 1'b1;
    end
  end

  // Output stage: load on accept, hold under backpressure, drop valid when drained or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.raddr1    <= '0;
      bus.raddr2    <= '0;
      bus.waddr     <= '0;
      bus.ruse1     <= 1'b0;
      bus.ruse2     <= 1'b0;
      bus.wuse      <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.raddr1    <= src1;
      bus.raddr2    <= src2;
      bus.waddr     <= dst;
      bus.ruse1     <= use1;
      bus.ruse2     <= use2;
      bus.wuse      <= dst_use;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Any register with a write still in flight
  always_comb begin
    pend_any = 1'b0;
    for (int i = 0; i < NREG; i++) pend_any = pend_any | (cnt[i] != '0);
  end

endmodule

// File: tb/tb_reg_addr_scoreboard.sv
// Directed scenarios plus a randomized run against a behavioural model that
// keeps pending-write counts as plain integers and the output stage as a record.
module tb_reg_addr_scoreboard;

  localparam int AW   = 5;
  localparam int NR   = 32;
  localparam int CW   = 2;
  localparam int CMAX = 3;
  localparam int LINK = 31;
  localparam int W    = 18;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic sb_err;
  logic pend_any;

  reg_addr_scoreboard_if #(.ADDR_W(AW)) bus();

  reg_addr_scoreboard #(.ADDR_W(AW), .NREG(NR), .CNT_W(CW), .LINK_REG(LINK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .bus      (bus),
    .sb_err   (sb_err),
    .pend_any (pend_any)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit u1; int a1;
    bit u2; int a2;
    bit wu; int w;
  } dec_t;

  int           m_cnt [NR];
  bit           m_err;
  bit           m_ov;
  dec_t         m_od;
  logic [W-1:0] exp_q [$];

  function automatic logic [W-1:0] pack(dec_t d);
    return {d.u1, 5'(d.a1), d.u2, 5'(d.a2), d.wu, 5'(d.w)};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {bus.ruse1, bus.raddr1, bus.ruse2, bus.raddr2, bus.wuse, bus.waddr};
  endfunction

  // Reference decode: "no destination" is register 0
  function automatic dec_t m_decode();
    dec_t d;
    d.u1 = 0; d.a1 = 0; d.u2 = 0; d.a2 = 0; d.wu = 0; d.w = 0;
    case (int'(bus.optype))
      0: begin d.u1 = 1; d.a1 = bus.rs; d.u2 = 1; d.a2 = bus.rt; d.w = bus.rd; end
      1: begin
        d.u1 = 1; d.a1 = bus.rs;
        if (bus.rt_src) begin d.u2 = 1; d.a2 = bus.rt; end
        else d.w = bus.rt;
      end
      2: if (bus.link) d.w = LINK;
      default: begin d.u1 = 1; d.a1 = bus.rs; if (bus.link) d.w = bus.rd; end
    endcase
    d.wu = (d.w != 0);
    return d;
  endfunction

  function automatic bit m_ready();
    dec_t d;
    bit   haz;
    d   = m_decode();
    haz = (d.u1 && d.a1 != 0 && m_cnt[d.a1] > 0) ||
          (d.u2 && d.a2 != 0 && m_cnt[d.a2] > 0) ||
          (d.wu && m_cnt[d.w] == CMAX);
    return (!m_ov || bus.out_ready) && !haz && !flush;
  endfunction

  function automatic bit m_pend();
    bit p = 0;
    foreach (m_cnt[i]) if (m_cnt[i] != 0) p = 1;
    return p;
  endfunction

  task automatic m_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_err = 0;
    m_ov  = 0;
    m_od  = '{default: 0};
    exp_q.delete();
  endtask

  // Advance one clock (from a negedge to the next) and update the model from the inputs seen at the edge
  task automatic cycle();
    dec_t d;
    bit   acc;
    int   nxt [NR];
    bit   nerr, nov;
    dec_t nod;
    d    = m_decode();
    acc  = bus.in_valid && m_ready();
    nxt  = m_cnt;
    nerr = m_err;
    nov  = m_ov;
    nod  = m_od;
    if (flush) begin
      foreach (nxt[i]) nxt[i] = 0;
      nov = 0;
    end else begin
      if (bus.wb_valid && bus.wb_addr != 0) begin
        if (m_cnt[bus.wb_addr] > 0) nxt[bus.wb_addr]--;
        else if (!(acc && d.wu && d.w == int'(bus.wb_addr))) nerr = 1;
      end
      if (acc && d.wu) nxt[d.w]++;
      if (acc) begin
        nov = 1;
        nod = d;
      end else if (bus.out_ready) begin
        nov = 0;
      end
    end
    @(posedge clk);
    m_cnt = nxt;
    m_err = nerr;
    m_ov  = nov;
    m_od  = nod;
    if (flush) exp_q.delete();
    else if (acc) exp_q.push_back(pack(d));
    @(negedge clk);
  endtask

  // driver tasks
  task automatic set_inst(int op, int rs_v, int rt_v, int rd_v, bit rts, bit lk, bit vld);
    bus.optype   = 2'(op);
    bus.rs       = 5'(rs_v);
    bus.rt       = 5'(rt_v);
    bus.rd       = 5'(rd_v);
    bus.rt_src   = rts;
    bus.link     = lk;
    bus.in_valid = vld;
  endtask

  task automatic idle();
    set_inst(0, 0, 0, 0, 0, 0, 0);
    bus.wb_valid = 0;
    bus.wb_addr  = '0;
    flush        = 0;
  endtask

  task automatic test_reset();
    rst_n         = 0;
    idle();
    bus.out_ready = 1;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++;
    if (dut_out() !== '0) begin n_bad++; $display("FAIL reset_fields: got %h want 0", dut_out()); end
    n_cmp++;
    if ({sb_err, pend_any} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {sb_err, pend_any}); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_r_type();
    set_inst(0, 1, 2, 3, 0, 0, 1);
    bus.out_ready = 1;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL r_in_ready: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    bus.in_valid = 0;
    #1;
    n_cmp++;
    if (bus.out_valid !== m_ov || dut_out() !== pack(m_od)) begin
      n_bad++; $display("FAIL r_out: got v=%b %h want v=%b %h", bus.out_valid, dut_out(), m_ov, pack(m_od));
    end
    n_cmp++;
    if (pend_any !== m_pend()) begin n_bad++; $display("FAIL r_pend: got %b want %b", pend_any, m_pend()); end
  endtask

  task automatic test_raw();
    set_inst(1, 3, 4, 0, 0, 0, 1);
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL raw_stall: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    bus.wb_valid = 1;
    bus.wb_addr  = 5'd3;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL raw_no_bypass: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    bus.wb_valid = 0;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL raw_release: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    bus.in_valid = 0;
    #1;
    n_cmp++;
    if (bus.out_valid !== m_ov || dut_out() !== pack(m_od)) begin
      n_bad++; $display("FAIL raw_issue: got v=%b %h want v=%b %h", bus.out_valid, dut_out(), m_ov, pack(m_od));
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin
      set_inst(0, 0, 0, 5, 0, 0, 1);
      #1;
      n_cmp++;
      if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL sat_issue%0d: got %b want %b", k, bus.in_ready, m_ready()); end
      cycle();
    end
    bus.wb_valid = 1;
    bus.wb_addr  = 5'd5;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL sat_hold: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    bus.wb_valid = 0;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL sat_release: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    idle();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1;
    cycle();
    set_inst(0, 0, 0, 6, 0, 0, 1);
    cycle();
    set_inst(0, 0, 0, 8, 0, 0, 1);
    bus.out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if (bus.in_ready !== m_ready() || bus.out_valid !== m_ov || dut_out() !== pack(m_od)) begin
        n_bad++; $display("FAIL bp_hold%0d: got rdy=%b v=%b %h want rdy=%b v=%b %h", k,
                          bus.in_ready, bus.out_valid, dut_out(), m_ready(), m_ov, pack(m_od));
      end
      cycle();
    end
    bus.out_ready = 1;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL bp_release: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    bus.in_valid = 0;
    #1;
    n_cmp++;
    if (dut_out() !== pack(m_od)) begin n_bad++; $display("FAIL bp_load: got %h want %h", dut_out(), pack(m_od)); end
  endtask

  task automatic test_reg0_link();
    set_inst(0, 0, 0, 0, 0, 0, 1);
    cycle();
    bus.in_valid = 0;
    #1;
    n_cmp++;
    if (dut_out() !== pack(m_od) || pend_any !== m_pend()) begin
      n_bad++; $display("FAIL rd0: got %h p=%b want %h p=%b", dut_out(), pend_any, pack(m_od), m_pend());
    end
    set_inst(2, 0, 0, 0, 0, 1, 1);
    cycle();
    set_inst(3, 31, 0, 0, 0, 0, 1);
    #1;
    n_cmp++;
    if (dut_out() !== pack(m_od)) begin n_bad++; $display("FAIL j_link: got %h want %h", dut_out(), pack(m_od)); end
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL jr_link_raw: got %b want %b", bus.in_ready, m_ready()); end
    idle();
    bus.wb_valid = 1;
    bus.wb_addr  = 5'd7;
    cycle();
    bus.wb_valid = 0;
    #1;
    n_cmp++;
    if (sb_err !== m_err) begin n_bad++; $display("FAIL sb_err_set: got %b want %b", sb_err, m_err); end
    repeat (3) cycle();
    #1;
    n_cmp++;
    if (sb_err !== m_err) begin n_bad++; $display("FAIL sb_err_sticky: got %b want %b", sb_err, m_err); end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      set_inst(0, 0, 0, 11 + k, 0, 0, 1);
      #1;
      n_cmp++;
      if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL b2b_rdy%0d: got %b want %b", k, bus.in_ready, m_ready()); end
      cycle();
      #1;
      n_cmp++;
      if (bus.out_valid !== m_ov || dut_out() !== pack(m_od)) begin
        n_bad++; $display("FAIL b2b_out%0d: got v=%b %h want v=%b %h", k, bus.out_valid, dut_out(), m_ov, pack(m_od));
      end
    end
    idle();
  endtask

  task automatic test_flush();
    set_inst(0, 0, 0, 9, 0, 0, 1);
    cycle();
    set_inst(0, 0, 0, 10, 0, 0, 1);
    flush = 1;
    #1;
    n_cmp++;
    if (bus.in_ready !== m_ready()) begin n_bad++; $display("FAIL flush_rdy: got %b want %b", bus.in_ready, m_ready()); end
    cycle();
    idle();
    #1;
    n_cmp++;
    if (pend_any !== m_pend() || bus.out_valid !== m_ov || sb_err !== m_err) begin
      n_bad++; $display("FAIL flush_state: got p=%b v=%b e=%b want p=%b v=%b e=%b",
                        pend_any, bus.out_valid, sb_err, m_pend(), m_ov, m_err);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    idle();
    bus.out_ready = 1;
    cycle();
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      set_inst($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.wb_valid  = ($urandom_range(0, 2) == 0);
      bus.wb_addr   = 5'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 39) == 0);
      #1;
      n_cmp++;
      if (bus.in_ready !== m_ready() || bus.out_valid !== m_ov || pend_any !== m_pend() || sb_err !== m_err) begin
        n_bad++; $display("FAIL rnd_ctl%0d: got rdy=%b v=%b p=%b e=%b want rdy=%b v=%b p=%b e=%b", k,
                          bus.in_ready, bus.out_valid, pend_any, sb_err, m_ready(), m_ov, m_pend(), m_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rnd_extra%0d: got %h want nothing", k, dut_out());
        end else begin
          exp = exp_q.pop_front();
          if (dut_out() !== exp) begin n_bad++; $display("FAIL rnd_data%0d: got %h want %h", k, dut_out(), exp); end
        end
      end
      cycle();
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1;
    set_inst(0, 0, 0, 12, 0, 0, 1);
    cycle();
    #3;
    rst_n = 0;
    m_reset();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || dut_out() !== '0 || pend_any !== 1'b0 || sb_err !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got v=%b %h p=%b e=%b want all 0", bus.out_valid, dut_out(), pend_any, sb_err);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || pend_any !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_accept: got v=%b p=%b want 0 0", bus.out_valid, pend_any);
    end
    idle();
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_raw();
    test_saturation();
    test_backpressure();
    test_reg0_link();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
